// File: rtl/ab_sequence_gen.sv
// Pattern sequencer: plays a small {a,b} symbol memory for a programmable
// number of steps and passes. A pass count of zero means the pattern repeats until stopped.
module ab_sequence_gen #(
  parameter int DEPTH = 8,
  parameter int RW    = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [1:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic [RW-1:0]            reps,
  input  logic                     start,
  input  logic                     stop,
  output logic                     a,
  output logic                     b,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] idx_r, idx_s, idx_inc_s;
  logic [RW-1:0] pc_r, pc_s, pc_inc_s;
  logic [AW-1:0] len_r, len_s;
  logic [RW-1:0] reps_r, reps_s;
  logic [1:0]    mem_r [DEPTH];

  logic          mem_we_s;
  logic          last_step_s;
  logic          last_pass_s;
  logic [1:0]    sym_s;
  logic          valid_s;
  logic          busy_s;
  logic          done_s;

  logic          a_r, b_r, valid_r, busy_r, done_r;

  assign idx_inc_s   = idx_r + AW'(1);
  assign pc_inc_s    = pc_r + RW'(1);
  assign last_step_s = (idx_r == len_r);
  // Pass counter free-wraps when reps is zero, so completion needs a nonzero target.
  assign last_pass_s = (reps_r != {RW{1'b0}}) && (pc_inc_s == reps_r);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    pc_s     = pc_r;
    len_s    = len_r;
    reps_s   = reps_r;
    mem_we_s = 1'b0;
    sym_s    = 2'b00;
    valid_s  = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        mem_we_s = wr_en;
        if (start && !stop) begin
          state_s = S_RUN;
          len_s   = len;
          reps_s  = reps;
          idx_s   = {AW{1'b0}};
          pc_s    = {RW{1'b0}};
          sym_s   = mem_r[0];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_s = S_IDLE;
        end else if (last_step_s && last_pass_s) begin
          state_s = S_DONE;
          done_s  = 1'b1;
        end else if (last_step_s) begin
          idx_s   = {AW{1'b0}};
          pc_s    = pc_inc_s;
          sym_s   = mem_r[0];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          idx_s   = idx_inc_s;
          sym_s   = mem_r[idx_inc_s];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters, latched parameters and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= S_IDLE;
      idx_r   <= {AW{1'b0}};
      pc_r    <= {RW{1'b0}};
      len_r   <= {AW{1'b0}};
      reps_r  <= {RW{1'b0}};
      a_r     <= 1'b0;
      b_r     <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      pc_r    <= pc_s;
      len_r   <= len_s;
      reps_r  <= reps_s;
      a_r     <= sym_s[1];
      b_r     <= sym_s[0];
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Pattern memory; writable only while idle so a running pattern is stable.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
    end else if (mem_we_s) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  assign a     = a_r;
  assign b     = b_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_ab_sequence_gen.sv
// Self-checking bench for ab_sequence_gen: directed scenarios followed by random
// traffic, checked against a sequence-level reference model.
module tb_ab_sequence_gen;

  localparam int DEPTH = 8;
  localparam int RW    = 4;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [1:0] wr_data = 2'd0;
  logic [2:0] len = 3'd0;
  logic [3:0] reps = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       a, b, valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  // Model: expected {valid,a,b,busy,done} now, plus the queue of future cycles.
  logic [4:0] cur = 5'b00000;
  logic [4:0] pend[$];
  logic [1:0] mm [DEPTH];

  ab_sequence_gen #(.DEPTH(DEPTH), .RW(RW)) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .reps(reps), .start(start), .stop(stop),
    .a(a), .b(b), .valid(valid), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [4:0] sym_entry(input logic [1:0] s);
    return {1'b1, s[1], s[0], 1'b1, 1'b0};
  endfunction

  task automatic model_edge();
    if (reset) begin
      cur = 5'b00000;
      pend.delete();
      for (int i = 0; i < DEPTH; i++) mm[i] = 2'b00;
    end else if (cur[4]) begin
      if (stop) begin
        cur = 5'b00000;
        pend.delete();
      end else begin
        cur = pend.pop_front();
      end
    end else if (cur[0]) begin
      cur = 5'b00000;
    end else begin
      if (start && !stop) begin
        pend.delete();
        if (reps == 4'd0) begin
          while (pend.size() < 300)
            for (int i = 0; i <= int'(len); i++) pend.push_back(sym_entry(mm[i]));
        end else begin
          for (int p = 0; p < int'(reps); p++)
            for (int i = 0; i <= int'(len); i++) pend.push_back(sym_entry(mm[i]));
          pend.push_back(5'b00001);
        end
        cur = pend.pop_front();
      end
      if (wr_en) mm[wr_addr] = wr_data;
    end
  endtask

  task automatic cyc(input string tag);
    logic [4:0] obs;
    @(posedge CLK);
    model_edge();
    #1;
    obs = {valid, a, b, busy, done};
    vectors++;
    assert (obs === cur) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (valid,a,b,busy,done)", tag, obs, cur);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic write_mem(input logic [2:0] ad, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = ad; wr_data = d;
    cyc("write");
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] l, input logic [3:0] r, input string tag);
    len = l; reps = r; start = 1'b1;
    cyc(tag);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = 2'b00;
    #2;
    // Reset state
    reset = 1'b1; cyc("reset"); cyc("reset");
    reset = 1'b0; cyc("post_reset");

    // Basic single pass
    write_mem(3'd0, 2'b10); write_mem(3'd1, 2'b01); write_mem(3'd2, 2'b11);
    do_start(3'd2, 4'd1, "r036_start");
    for (int i = 0; i < 5; i++) cyc("r036_run");

    // Three passes
    do_start(3'd2, 4'd3, "r037_start");
    for (int i = 0; i < 12; i++) cyc("r037_run");

    // Continuous single-symbol, then stop
    write_mem(3'd0, 2'b11);
    do_start(3'd0, 4'd0, "r038_start");
    for (int i = 0; i < 4; i++) cyc("r038_run");
    stop = 1'b1; cyc("r038_stop");
    stop = 1'b0;
    for (int i = 0; i < 3; i++) cyc("r038_after");

    // Writes and start ignored during RUN
    write_mem(3'd0, 2'b10);
    do_start(3'd2, 4'd1, "r039_start");
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 2'b00; start = 1'b1;
    cyc("r039_lock"); cyc("r039_lock");
    clear_inputs();
    for (int i = 0; i < 4; i++) cyc("r039_run");
    do_start(3'd2, 4'd1, "r039_restart");
    for (int i = 0; i < 4; i++) cyc("r039_rerun");

    // Reset mid-run clears memory
    do_start(3'd2, 4'd2, "r040_start");
    cyc("r040_run");
    reset = 1'b1; start = 1'b1; wr_en = 1'b1; stop = 1'b1; cyc("r040_reset");
    clear_inputs();
    cyc("r040_idle");
    do_start(3'd2, 4'd1, "r040_restart");
    for (int i = 0; i < 4; i++) cyc("r040_run2");

    // Stop on the final symbol; start+stop in idle
    write_mem(3'd0, 2'b10); write_mem(3'd1, 2'b01); write_mem(3'd2, 2'b11);
    do_start(3'd2, 4'd1, "r041_start");
    cyc("r041_run"); cyc("r041_run");
    stop = 1'b1; cyc("r041_stop_last");
    start = 1'b1; cyc("r041_start_stop");
    clear_inputs();
    cyc("r041_idle"); cyc("r041_idle");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 11) == 0) || (cur[4] && pend.size() < 20);
      wr_en = !start && ($urandom_range(0, 2) == 0);
      wr_addr = 3'($urandom_range(0, DEPTH - 1));
      wr_data = 2'($urandom_range(0, 3));
      len  = 3'($urandom_range(0, DEPTH - 1));
      reps = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      cyc("random");
    end
    clear_inputs();
    cyc("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
